// File: rtl/hazard_tag_pipe_pkg.sv
// Shared types for the hazard/tag pipeline: register tag width,
// FSM encoding and the per-stage tag bundle.
package hazard_tag_pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             regWrite;
    logic             memRead;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/hazard_tag_pipe_detect.sv
// Combinational load-use detection and stall/flush priority
// (mem wait over branch over load-use).
module hazard_detect
  import hazard_tag_pipe_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  stage_t           id_ex,
  input  logic             in_lu,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             bubble,
  output logic             hold,
  output logic             lu_stall
);

  logic lu_raw;
  logic br;
  logic lu;

  always_comb begin
    lu_raw = id_valid & id_ex.memRead & id_ex.regWrite
           & (id_ex.rd != '0)
           & ((id_ex.rd == id_rs1) | (id_ex.rd == id_rs2))
           & ~in_lu;
    br = ex_branch_taken & ~mem_busy;
    lu = lu_raw & ~br & ~mem_busy;

    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    bubble      = 1'b0;
    hold        = 1'b0;
    lu_stall    = 1'b0;

    unique case (1'b1)
      mem_busy: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        hold        = 1'b1;
      end
      br: begin
        if_id_flush = 1'b1;
        bubble      = 1'b1;
      end
      lu: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        bubble      = 1'b1;
        lu_stall    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_tag_pipe.sv
// ID/EX, EX/MEM, MEM/WB tag registers with stall FSM, wait
// timeout and saturating stall counter.
module hazard_tag_pipe
  import hazard_tag_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regWrite,
  input  logic             id_memRead,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic [REG_W-1:0] ID_EX_rs1,
  output logic [REG_W-1:0] ID_EX_rs2,
  output logic [REG_W-1:0] ID_EX_rd,
  output logic             ID_EX_regWrite,
  output logic             ID_EX_memRead,
  output logic [REG_W-1:0] EX_MEM_rd,
  output logic             EX_MEM_regWrite,
  output logic [REG_W-1:0] MEM_WB_rd,
  output logic             MEM_WB_regWrite,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  stage_t id_ex_q, id_ex_d;
  stage_t ex_mem_q, ex_mem_d;
  stage_t mem_wb_q, mem_wb_d;
  stage_t id_stage;
  state_e state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic mem_timeout_q, mem_timeout_d;

  logic pc_write_raw, if_id_write_raw, if_id_flush_raw;
  logic bubble, hold, lu_stall;

  hazard_detect u_detect (
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_ex           (id_ex_q),
    .in_lu           (state_q == LU_STALL),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write_raw),
    .if_id_write     (if_id_write_raw),
    .if_id_flush     (if_id_flush_raw),
    .bubble          (bubble),
    .hold            (hold),
    .lu_stall        (lu_stall)
  );

  always_comb begin
    id_stage = BUBBLE;
    if (id_valid) begin
      id_stage = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                   regWrite: id_regWrite, memRead: id_memRead};
    end

    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (!hold) begin
      id_ex_d  = bubble ? BUBBLE : id_stage;
      ex_mem_d = id_ex_q;
      mem_wb_d = ex_mem_q;
    end

    state_d = RUN;
    unique case (1'b1)
      mem_busy: state_d = MEM_WAIT;
      lu_stall: state_d = LU_STALL;
      default:  state_d = RUN;
    endcase

    wait_cnt_d = '0;
    if (mem_busy) begin
      wait_cnt_d = (wait_cnt_q == WMAX) ? wait_cnt_q
                                        : wait_cnt_q + WW'(1);
    end
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == WMAX);

    stall_cnt_d = stall_cnt_q;
    if (!pc_write_raw && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q       <= BUBBLE;
      ex_mem_q      <= BUBBLE;
      mem_wb_q      <= BUBBLE;
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      id_ex_q       <= id_ex_d;
      ex_mem_q      <= ex_mem_d;
      mem_wb_q      <= mem_wb_d;
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign ID_EX_rs1       = id_ex_q.rs1;
  assign ID_EX_rs2       = id_ex_q.rs2;
  assign ID_EX_rd        = id_ex_q.rd;
  assign ID_EX_regWrite  = id_ex_q.regWrite;
  assign ID_EX_memRead   = id_ex_q.memRead;
  assign EX_MEM_rd       = ex_mem_q.rd;
  assign EX_MEM_regWrite = ex_mem_q.regWrite;
  assign MEM_WB_rd       = mem_wb_q.rd;
  assign MEM_WB_regWrite = mem_wb_q.regWrite;
  // Control stays deasserted for as long as reset is held.
  assign pc_write        = rst_n & pc_write_raw;
  assign if_id_write     = rst_n & if_id_write_raw;
  assign if_id_flush     = rst_n & if_id_flush_raw;
  assign stall_cnt       = stall_cnt_q;
  assign mem_timeout     = mem_timeout_q;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed testbench for hazard_tag_pipe: one task per scenario,
// expected values computed by hand.
module tb_hazard_tag_pipe;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regWrite, id_memRead;
  logic       ex_branch_taken, mem_busy;
  logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic       ID_EX_regWrite, ID_EX_memRead;
  logic [4:0] EX_MEM_rd, MEM_WB_rd;
  logic       EX_MEM_regWrite, MEM_WB_regWrite;
  logic       pc_write, if_id_write, if_id_flush;
  logic [7:0] stall_cnt;
  logic       mem_timeout;

  int total;
  int passed;

  hazard_tag_pipe #(.MAX_WAIT(16), .CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_regWrite     (id_regWrite),
    .id_memRead      (id_memRead),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .ID_EX_rs1       (ID_EX_rs1),
    .ID_EX_rs2       (ID_EX_rs2),
    .ID_EX_rd        (ID_EX_rd),
    .ID_EX_regWrite  (ID_EX_regWrite),
    .ID_EX_memRead   (ID_EX_memRead),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_regWrite (EX_MEM_regWrite),
    .MEM_WB_rd       (MEM_WB_rd),
    .MEM_WB_regWrite (MEM_WB_regWrite),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .stall_cnt       (stall_cnt),
    .mem_timeout     (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_regWrite = rw; id_memRead = mr;
  endtask

  task automatic test_reset();
    logic [29:0] all_out;
    rst_n = 1'b0;
    put(0, 0, 0, 0, 0, 0);
    ex_branch_taken = 1'b0;
    mem_busy = 1'b0;
    #3;
    all_out = {ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_regWrite,
               ID_EX_memRead, EX_MEM_rd, EX_MEM_regWrite,
               MEM_WB_rd, MEM_WB_regWrite, mem_timeout};
    total++;
    if (all_out !== '0) $display("FAIL reset_tags: got %h want 0", all_out);
    else passed++;
    total++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b000)
      $display("FAIL reset_ctrl: got %b want 000", {pc_write, if_id_write, if_id_flush});
    else passed++;
    total++;
    if (stall_cnt !== 8'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_hazard();
    put(1, 1, 2, 5, 1, 0);
    tick();
    put(1, 3, 4, 6, 1, 0);
    #1;
    total++;
    if (pc_write !== 1'b1) $display("FAIL nh_pc_write: got %b want 1", pc_write);
    else passed++;
    tick();
    put(0, 0, 0, 0, 0, 0);
    total++;
    if ({EX_MEM_rd, ID_EX_rd} !== {5'd5, 5'd6})
      $display("FAIL nh_ex_mem: got %0d/%0d want 5/6", EX_MEM_rd, ID_EX_rd);
    else passed++;
    tick();
    total++;
    if ({MEM_WB_rd, EX_MEM_rd, MEM_WB_regWrite} !== {5'd5, 5'd6, 1'b1})
      $display("FAIL nh_mem_wb: got %0d/%0d want 5/6", MEM_WB_rd, EX_MEM_rd);
    else passed++;
    total++;
    if (stall_cnt !== 8'd0 || pc_write !== 1'b1)
      $display("FAIL nh_stall_cnt: got %0d pc_write %b want 0/1", stall_cnt, pc_write);
    else passed++;
  endtask

  task automatic test_load_use();
    put(1, 2, 0, 7, 1, 1);
    tick();
    put(1, 7, 1, 8, 1, 0);
    #1;
    total++;
    if ({pc_write, if_id_write} !== 2'b00)
      $display("FAIL lu_stall_ctrl: got %b want 00", {pc_write, if_id_write});
    else passed++;
    tick();
    total++;
    if ({ID_EX_rd, ID_EX_regWrite, ID_EX_memRead, EX_MEM_rd} !== {5'd0, 2'b00, 5'd7})
      $display("FAIL lu_bubble: got rd %0d ex_mem %0d want 0/7", ID_EX_rd, EX_MEM_rd);
    else passed++;
    total++;
    if ({pc_write, if_id_write} !== 2'b11)
      $display("FAIL lu_one_cycle: got %b want 11", {pc_write, if_id_write});
    else passed++;
    tick();
    put(0, 0, 0, 0, 0, 0);
    total++;
    if ({ID_EX_rd, ID_EX_rs1} !== {5'd8, 5'd7})
      $display("FAIL lu_add_enters: got rd %0d rs1 %0d want 8/7", ID_EX_rd, ID_EX_rs1);
    else passed++;
    total++;
    if (stall_cnt !== 8'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
    else passed++;
  endtask

  task automatic test_x0();
    put(1, 2, 0, 0, 1, 1);
    tick();
    put(1, 0, 0, 9, 1, 0);
    #1;
    total++;
    if (pc_write !== 1'b1) $display("FAIL x0_pc_write: got %b want 1", pc_write);
    else passed++;
    tick();
    put(0, 0, 0, 0, 0, 0);
    total++;
    if ({ID_EX_rd, EX_MEM_rd, EX_MEM_regWrite} !== {5'd9, 5'd0, 1'b1})
      $display("FAIL x0_propagate: got %0d/%0d/%b want 9/0/1", ID_EX_rd, EX_MEM_rd, EX_MEM_regWrite);
    else passed++;
    total++;
    if (stall_cnt !== 8'd1) $display("FAIL x0_stall_cnt: got %0d want 1", stall_cnt);
    else passed++;
  endtask

  task automatic test_branch();
    put(1, 1, 0, 10, 1, 1);
    tick();
    put(1, 10, 3, 11, 1, 0);
    ex_branch_taken = 1'b1;
    #1;
    total++;
    if ({if_id_flush, pc_write} !== 2'b11)
      $display("FAIL br_ctrl: got %b want 11", {if_id_flush, pc_write});
    else passed++;
    tick();
    ex_branch_taken = 1'b0;
    put(0, 0, 0, 0, 0, 0);
    total++;
    if ({ID_EX_rd, ID_EX_regWrite, ID_EX_memRead, EX_MEM_rd} !== {5'd0, 2'b00, 5'd10})
      $display("FAIL br_bubble: got rd %0d ex_mem %0d want 0/10", ID_EX_rd, EX_MEM_rd);
    else passed++;
    total++;
    if (stall_cnt !== 8'd1 || pc_write !== 1'b1)
      $display("FAIL br_no_stall: got %0d pc_write %b want 1/1", stall_cnt, pc_write);
    else passed++;
  endtask

  task automatic test_mem_wait();
    put(1, 1, 2, 12, 1, 0);
    tick();
    put(1, 1, 2, 13, 1, 0);
    tick();
    put(1, 1, 2, 14, 1, 0);
    tick();
    put(1, 1, 2, 15, 1, 0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({pc_write, if_id_write, if_id_flush} !== 3'b000)
        $display("FAIL mw_ctrl_%0d: got %b want 000", i, {pc_write, if_id_write, if_id_flush});
      else passed++;
      tick();
      total++;
      if ({ID_EX_rd, EX_MEM_rd, MEM_WB_rd} !== {5'd14, 5'd13, 5'd12})
        $display("FAIL mw_hold_%0d: got %0d/%0d/%0d want 14/13/12", i, ID_EX_rd, EX_MEM_rd, MEM_WB_rd);
      else passed++;
    end
    total++;
    if (stall_cnt !== 8'd4) $display("FAIL mw_stall_cnt: got %0d want 4", stall_cnt);
    else passed++;
    mem_busy = 1'b0;
    #1;
    total++;
    if (pc_write !== 1'b1) $display("FAIL mw_resume_pc: got %b want 1", pc_write);
    else passed++;
    tick();
    put(0, 0, 0, 0, 0, 0);
    total++;
    if ({ID_EX_rd, EX_MEM_rd, MEM_WB_rd} !== {5'd15, 5'd14, 5'd13})
      $display("FAIL mw_resume: got %0d/%0d/%0d want 15/14/13", ID_EX_rd, EX_MEM_rd, MEM_WB_rd);
    else passed++;
    total++;
    if (stall_cnt !== 8'd4 || mem_timeout !== 1'b0)
      $display("FAIL mw_after: got %0d/%b want 4/0", stall_cnt, mem_timeout);
    else passed++;
  endtask

  task automatic test_timeout();
    logic [29:0] all_out;
    mem_busy = 1'b1;
    repeat (15) tick();
    total++;
    if (mem_timeout !== 1'b0) $display("FAIL to_early: got %b want 0", mem_timeout);
    else passed++;
    tick();
    total++;
    if (mem_timeout !== 1'b1) $display("FAIL to_rise: got %b want 1", mem_timeout);
    else passed++;
    repeat (2) tick();
    mem_busy = 1'b0;
    tick();
    total++;
    if (mem_timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", mem_timeout);
    else passed++;
    total++;
    if (stall_cnt !== 8'd22) $display("FAIL to_stall_cnt: got %0d want 22", stall_cnt);
    else passed++;
    mem_busy = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    all_out = {ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_regWrite,
               ID_EX_memRead, EX_MEM_rd, EX_MEM_regWrite,
               MEM_WB_rd, MEM_WB_regWrite, mem_timeout};
    total++;
    if (all_out !== '0) $display("FAIL to_async_rst: got %h want 0", all_out);
    else passed++;
    total++;
    if (stall_cnt !== 8'd0 || pc_write !== 1'b0)
      $display("FAIL to_rst_cnt: got %0d pc_write %b want 0/0", stall_cnt, pc_write);
    else passed++;
    @(negedge clk);
    mem_busy = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    mem_busy = 1'b1;
    repeat (255) tick();
    total++;
    if (stall_cnt !== 8'd255) $display("FAIL sat_reach: got %0d want 255", stall_cnt);
    else passed++;
    repeat (3) tick();
    total++;
    if (stall_cnt !== 8'd255) $display("FAIL sat_hold: got %0d want 255", stall_cnt);
    else passed++;
    mem_busy = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_no_hazard();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
